data_sram_responder: RTL and testbench
======================================

Name: data_sram_responder

Overview:
- Memory-side responder for the CPU data-access port: accepts SRAM-like requests (req/wr/size/addr/wstrb/wdata), checks strobe/size/alignment legality, performs byte-masked writes or word reads on an internal RAM, and returns data_ok/rdata after a fixed latency.
- The CPU-side load formatter extracts and sign/zero-extends bytes and halfwords from the returned word, so this block always returns the full aligned word.
- Used as the data memory in simulation and FPGA builds without a cache/AXI path.

Parameters:
- ADDR_W, 12, word-index width; RAM holds 2^ADDR_W 32-bit words.
- LATENCY, 2, cycles from accept edge to data_ok; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  synchronous active-low reset.
- req  in  1  request valid.
- wr  in  1  1 = write, 0 = read.
- size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- addr  in  32  byte address; bits [ADDR_W+1:2] index the RAM, higher bits ignored (alias).
- wstrb  in  4  byte enables for writes; ignored on reads.
- wdata  in  32  write data, already lane-replicated by the CPU.
- addr_ok  out  1  request accepted this cycle when req && addr_ok.
- data_ok  out  1  one-cycle response pulse.
- rdata  out  32  read word, valid with data_ok.
- err  out  1  request was illegal, valid with data_ok.

Behaviour:
- Interface: one clock; reset is synchronous and active-low (clk, resetn).
- Reset values: addr_ok=0 during reset, then 1 in IDLE; data_ok=0, rdata=0, err=0, state=IDLE, count=0. RAM contents are not cleared.
- FSM states:
  - IDLE: addr_ok=1. Accept goes to WAIT with count=LATENCY-1, or straight to RESP if LATENCY==1.
  - WAIT: addr_ok=0. count decrements each cycle; at count==1 go to RESP.
  - RESP: data_ok=1 and addr_ok=1. An accept in this cycle goes to WAIT/RESP as from IDLE; otherwise go to IDLE.
- Latency: a request accepted at edge T gives data_ok=1 during the cycle after edge T+LATENCY-1, i.e. exactly LATENCY cycles later. Throughput is one request per LATENCY cycles; back-to-back accepts are possible in RESP.
- Accepted request fields (wr, size, addr, wstrb, wdata) are latched at accept. Inputs are don't-care while addr_ok=0.
- Legality, evaluated on latched fields:
  - size 00: any addr[1:0]; write wstrb must be one-hot at bit addr[1:0].
  - size 01: addr[0] must be 0; write wstrb must be 0011 (addr[1]=0) or 1100 (addr[1]=1).
  - size 10: addr[1:0] must be 00; write wstrb must be 1111.
  - size 11: always illegal.
  - Write with wstrb=0000 and legal size/alignment is a legal no-op.
- Illegal request: err=1, data_ok=1, rdata=0, RAM unchanged.
- Legal write: RAM bytes with wstrb[i]=1 take wdata[8i+7:8i]; committed on the RESP edge; err=0, rdata=0.
- Legal read: rdata = RAM word at the latched index, sampled in RESP. The value reflects all writes whose RESP preceded it.
- Simultaneous accept in RESP: the new request is latched; the current response is unaffected.
- Reset mid-operation: a pending request is discarded with no RAM write and no data_ok pulse after reset.
- Address wrap: index = addr[ADDR_W+1:2]; upper bits are never checked.

Decomposition:
- Shared defines header gains SIZE_BYTE=2'b00, SIZE_HALF=2'b01, SIZE_WORD=2'b10 alongside the existing EXE_*_OP constants.
- Sub-module data_ram_bank: single-port RAM, 4 byte write-enables, synchronous write, combinational read, parameter ADDR_W.
- The FSM, legality check and latches stay in data_sram_responder.

Test Plan:
- LATENCY=2: write addr=0x10, size=10, wstrb=1111, wdata=0xDEADBEEF accepted at T; data_ok=1 at T+2 with err=0. Read 0x10 then returns rdata=0xDEADBEEF.
- Byte write addr=0x13, size=00, wstrb=1000, wdata=0x55555555 over 0xDEADBEEF; read 0x10 returns 0x55ADBEEF.
- Illegal requests:
  - Half read addr=0x11 gives data_ok with err=1, rdata=0.
  - Word write addr=0x12 gives err=1 and a following read of 0x10 is unchanged.
  - Size=11 gives err=1.
- Strobe mismatch: size=01, addr=0x10, wstrb=1100 gives err=1 with no RAM change. A legal wstrb=0000 write gives err=0 with no RAM change.
- Back-to-back with req held high for 4 requests, LATENCY=1: addr_ok stays 1 and data_ok pulses every cycle from T+1. With LATENCY=3: addr_ok=0 for 2 cycles after each accept.
- resetn=0 for one cycle while in WAIT after a write accept: no data_ok afterwards, RAM word unchanged, outputs at reset values, addr_ok=1 the next cycle.

Source files
------------

// File: rtl/data_sram_responder_pkg.sv
// Shared types and constants for the data SRAM responder.
// Holds access sizes, FSM states and the request legality check.
package data_sram_responder_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  // strobe 0000 on an aligned write is a legal no-op
  function automatic logic req_legal(
    input logic       wr,
    input logic [1:0] size,
    input logic [1:0] a,
    input logic [3:0] strb
  );
    logic [3:0] need;
    logic       al;
    need = 4'b0000;
    al   = 1'b0;
    unique case (1'b1)
      size == SIZE_BYTE: begin
        al   = 1'b1;
        need = 4'b0001 << a;
      end
      size == SIZE_HALF: begin
        al   = !a[0];
        need = a[1] ? 4'b1100 : 4'b0011;
      end
      size == SIZE_WORD: begin
        al   = (a == 2'b00);
        need = 4'b1111;
      end
      default: begin
        al   = 1'b0;
        need = 4'b0000;
      end
    endcase
    return al && (!wr || strb == 4'b0000 || strb == need);
  endfunction

endpackage

// File: rtl/data_sram_responder_if.sv
// SRAM-like data port between the CPU and the data memory.
// master = CPU side, slave = memory responder.
interface data_sram_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, wr, size, addr, wstrb, wdata,
    input  addr_ok, data_ok, rdata, err
  );

  modport slave (
    input  req, wr, size, addr, wstrb, wdata,
    output addr_ok, data_ok, rdata, err
  );
endinterface

// File: rtl/data_ram_bank.sv
// Single-port word RAM with per-byte write enables.
// Synchronous write, combinational read.
module data_ram_bank #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] idx,
  input  logic [3:0]        we,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/data_sram_responder.sv
// Data memory responder: accepts one request per LATENCY cycles,
// checks legality, and answers with data_ok/rdata/err.
module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int LATENCY = 2
) (
  input  logic   clk,
  input  logic   resetn,
  data_sram_if.slave bus
);

  state_t            state, nxt;
  logic [3:0]        count, cnt_nxt;
  logic              ardy, rsp, acc, ok;
  logic              wr_q;
  logic [1:0]        size_q;
  logic [1:0]        alo_q;
  logic [ADDR_W-1:0] idx_q;
  logic [3:0]        strb_q;
  logic [31:0]       wdata_q;
  logic [3:0]        we;
  logic [31:0]       ram_q;
  logic              unused_hi;

  // upper address bits alias onto the same words
  assign unused_hi = ^bus.addr[31:ADDR_W+2];

  assign acc = bus.req && ardy;
  assign ok  = req_legal(wr_q, size_q, alo_q, strb_q);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= S_IDLE;
      count <= '0;
    end else begin
      state <= nxt;
      count <= cnt_nxt;
    end
  end

  always_comb begin
    nxt     = state;
    cnt_nxt = count;
    unique case (state)
      S_IDLE, S_RESP: begin
        if (acc) begin
          nxt     = (LATENCY == 1) ? S_RESP : S_WAIT;
          cnt_nxt = 4'(LATENCY - 1);
        end else begin
          nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        cnt_nxt = count - 4'd1;
        if (count == 4'd1) nxt = S_RESP;
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ardy        = resetn && (state == S_IDLE || state == S_RESP);
    rsp         = resetn && (state == S_RESP);
    bus.addr_ok = ardy;
    bus.data_ok = rsp;
    bus.err     = rsp && !ok;
    bus.rdata   = (rsp && ok && !wr_q) ? ram_q : 32'h0;
    we          = (rsp && ok && wr_q) ? strb_q : 4'b0000;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_q    <= 1'b0;
      size_q  <= SIZE_BYTE;
      alo_q   <= 2'b00;
      idx_q   <= '0;
      strb_q  <= 4'b0000;
      wdata_q <= 32'h0;
    end else if (acc) begin
      wr_q    <= bus.wr;
      size_q  <= bus.size;
      alo_q   <= bus.addr[1:0];
      idx_q   <= bus.addr[ADDR_W+1:2];
      strb_q  <= bus.wstrb;
      wdata_q <= bus.wdata;
    end
  end

  data_ram_bank #(.ADDR_W(ADDR_W)) u_bank (
    .clk   (clk),
    .idx   (idx_q),
    .we    (we),
    .wdata (wdata_q),
    .rdata (ram_q)
  );

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench for data_sram_responder at LATENCY 1, 2 and 3.
// Expected responses go through a scoreboard queue.
module tb_data_sram_responder;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  data_sram_if b1 ();
  data_sram_if b2 ();
  data_sram_if b3 ();

  data_sram_responder #(.ADDR_W(12), .LATENCY(1)) dut1 (
    .clk(clk), .resetn(resetn), .bus(b1));
  data_sram_responder #(.ADDR_W(12), .LATENCY(2)) dut2 (
    .clk(clk), .resetn(resetn), .bus(b2));
  data_sram_responder #(.ADDR_W(12), .LATENCY(3)) dut3 (
    .clk(clk), .resetn(resetn), .bus(b3));

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic e, input logic [31:0] r);
    exp_t x;
    x.err   = e;
    x.rdata = r;
    sb.push_back(x);
  endtask

  task automatic pop_chk(input string tag, input logic e,
                         input logic [31:0] r);
    exp_t x;
    chk({tag, "_sb"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      x = sb.pop_front();
      chk({tag, "_err"}, 32'(e), 32'(x.err));
      chk({tag, "_rdata"}, r, x.rdata);
    end
  endtask

  task automatic req2(input string tag, input logic wr,
                      input logic [1:0] size, input logic [31:0] addr,
                      input logic [3:0] strb, input logic [31:0] wd,
                      input logic e, input logic [31:0] r);
    int n;
    b2.req = 1'b1; b2.wr = wr; b2.size = size;
    b2.addr = addr; b2.wstrb = strb; b2.wdata = wd;
    n = 0;
    while (!b2.addr_ok && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, "_addr_ok"}, 32'(b2.addr_ok), 32'd1);
    @(posedge clk);
    push(e, r);
    #1 b2.req = 1'b0;
    n = 0;
    while (!b2.data_ok && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'd1);
    if (b2.data_ok) pop_chk(tag, b2.err, b2.rdata);
  endtask

  initial begin
    logic [5:0] pat;
    logic       seen;
    {b1.req, b1.wr, b1.size, b1.addr, b1.wstrb, b1.wdata} = '0;
    {b2.req, b2.wr, b2.size, b2.addr, b2.wstrb, b2.wdata} = '0;
    {b3.req, b3.wr, b3.size, b3.addr, b3.wstrb, b3.wdata} = '0;

    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_addr_ok", 32'(b2.addr_ok), 32'd0);
    chk("rst_data_ok", 32'(b2.data_ok), 32'd0);
    chk("rst_rdata", b2.rdata, 32'h0);
    chk("rst_err", 32'(b2.err), 32'd0);
    resetn = 1'b1;
    #1 chk("idle_addr_ok", 32'(b2.addr_ok), 32'd1);

    req2("wr_word", 1, 2'b10, 32'h10, 4'hF, 32'hDEADBEEF, 0, 32'h0);
    req2("rd_word", 0, 2'b10, 32'h10, 4'h0, 32'h0, 0, 32'hDEADBEEF);
    req2("wr_byte", 1, 2'b00, 32'h13, 4'b1000, 32'h55555555, 0, 32'h0);
    req2("rd_byte", 0, 2'b10, 32'h10, 4'h0, 32'h0, 0, 32'h55ADBEEF);
    req2("half_mis", 0, 2'b01, 32'h11, 4'h0, 32'h0, 1, 32'h0);
    req2("word_mis", 1, 2'b10, 32'h12, 4'hF, 32'h0, 1, 32'h0);
    req2("rd_mis", 0, 2'b10, 32'h10, 4'h0, 32'h0, 0, 32'h55ADBEEF);
    req2("size11", 0, 2'b11, 32'h10, 4'h0, 32'h0, 1, 32'h0);
    req2("strb_bad", 1, 2'b01, 32'h10, 4'b1100, 32'h0, 1, 32'h0);
    req2("rd_strb", 0, 2'b10, 32'h10, 4'h0, 32'h0, 0, 32'h55ADBEEF);
    req2("wr_nop", 1, 2'b10, 32'h10, 4'h0, 32'h0, 0, 32'h0);
    req2("rd_nop", 0, 2'b10, 32'h10, 4'h0, 32'h0, 0, 32'h55ADBEEF);
    req2("rd_alias", 0, 2'b10, 32'h4010, 4'h0, 32'h0, 0, 32'h55ADBEEF);
    req2("wr_half", 1, 2'b01, 32'h12, 4'b1100, 32'hA5A5A5A5, 0, 32'h0);
    req2("rd_half", 0, 2'b10, 32'h10, 4'h0, 32'h0, 0, 32'hA5A5BEEF);
    req2("wr_20", 1, 2'b10, 32'h20, 4'hF, 32'h12345678, 0, 32'h0);

    // reset while a write is waiting
    b2.req = 1'b1; b2.wr = 1'b1; b2.size = 2'b10;
    b2.addr = 32'h20; b2.wstrb = 4'hF; b2.wdata = 32'hFFFFFFFF;
    @(posedge clk);
    #1 b2.req = 1'b0;
    resetn = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_data_ok", 32'(b2.data_ok), 32'd0);
    chk("mid_rst_addr_ok", 32'(b2.addr_ok), 32'd0);
    chk("mid_rst_rdata", b2.rdata, 32'h0);
    chk("mid_rst_err", 32'(b2.err), 32'd0);
    resetn = 1'b1;
    @(negedge clk);
    chk("post_rst_addr_ok", 32'(b2.addr_ok), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      seen = seen | b2.data_ok;
    end
    chk("post_rst_no_resp", 32'(seen), 32'd0);
    req2("rd_20", 0, 2'b10, 32'h20, 4'h0, 32'h0, 0, 32'h12345678);

    // LATENCY 1, req held for four writes
    b1.req = 1'b1; b1.wr = 1'b1; b1.size = 2'b10;
    b1.wstrb = 4'hF; b1.addr = 32'h40; b1.wdata = 32'h11111111;
    chk("l1_addr_ok_idle", 32'(b1.addr_ok), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      push(0, 32'h0);
      #1;
      chk("l1_addr_ok", 32'(b1.addr_ok), 32'd1);
      chk("l1_data_ok", 32'(b1.data_ok), 32'd1);
      if (b1.data_ok) pop_chk("l1", b1.err, b1.rdata);
      b1.addr  = 32'h44 + 32'(4 * i);
      b1.wdata = 32'h11111111 * 32'(i + 2);
      if (i == 3) b1.req = 1'b0;
    end
    @(posedge clk); #1;
    chk("l1_idle_data_ok", 32'(b1.data_ok), 32'd0);
    b1.req = 1'b1; b1.wr = 1'b0; b1.addr = 32'h48;
    @(posedge clk);
    push(0, 32'h33333333);
    #1 b1.req = 1'b0;
    chk("l1_rd_data_ok", 32'(b1.data_ok), 32'd1);
    if (b1.data_ok) pop_chk("l1_rd", b1.err, b1.rdata);

    // LATENCY 3, two accepts with req held
    b3.req = 1'b1; b3.wr = 1'b1; b3.size = 2'b10;
    b3.wstrb = 4'hF; b3.addr = 32'h0; b3.wdata = 32'hCAFEF00D;
    pat = 6'b100100;
    for (int e = 1; e <= 6; e++) begin
      @(posedge clk);
      if (e == 1) push(0, 32'h0);
      if (e == 4) push(1, 32'h0);
      #1;
      chk("l3_addr_ok", 32'(b3.addr_ok), 32'(pat[e-1]));
      chk("l3_data_ok", 32'(b3.data_ok), 32'(pat[e-1]));
      if (b3.data_ok) pop_chk("l3", b3.err, b3.rdata);
      if (e == 3) begin
        b3.wr = 1'b0; b3.size = 2'b11;
      end
      if (e == 4) b3.req = 1'b0;
    end
    @(posedge clk); #1;
    chk("l3_idle_addr_ok", 32'(b3.addr_ok), 32'd1);
    chk("l3_idle_data_ok", 32'(b3.data_ok), 32'd0);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
